// File: rtl/sdp_ram_fifo_pkg.sv
// Shared FIFO helpers: ceil-log2 and skid depth derived from RAM read latency.
// Pure constant functions, no logic.
package sdp_ram_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Two spare entries over the read latency let the output stream at full rate.
    function automatic int skid_depth(input int latency);
        return latency + 2;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write and one read port, read-before-write.
// Read data appears LATENCY cycles after r_addr; no backpressure, contents not reset.
module sdp_ram #(
    parameter int D_WIDTH = 72,
    parameter int A_WIDTH = 10,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] w_addr,
    input  logic [D_WIDTH-1:0] din,
    input  logic [A_WIDTH-1:0] r_addr,
    output logic [D_WIDTH-1:0] dout
);

    logic [D_WIDTH-1:0] mem  [2**A_WIDTH];
    logic [D_WIDTH-1:0] pipe [LATENCY];

    always_ff @(posedge clk) begin
        if (we) mem[w_addr] <= din;
        pipe[0] <= mem[r_addr];
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[LATENCY-1];

endmodule

// File: rtl/sdp_ram_fifo_skid.sv
// Small register FIFO catching RAM read data; head is a register output.
// Zero-latency head; caller guarantees no push when full and no pop when empty.
module sdp_ram_fifo_skid
    import sdp_ram_fifo_pkg::*;
#(
    parameter int D_WIDTH = 72,
    parameter int DEPTH   = 4,
    parameter int CW      = clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [D_WIDTH-1:0] head,
    output logic [CW-1:0]      cnt
);

    localparam int IW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/sdp_ram_fifo.sv
// Valid/ready FIFO over an sdp_ram, prefetching reads into a skid buffer; first word out LATENCY+2 cycles after push.
// in_ready = RAM not full; out_ready only pops the skid head, never reaches the RAM combinationally.
module sdp_ram_fifo
    import sdp_ram_fifo_pkg::*;
#(
    parameter int D_WIDTH = 72,
    parameter int A_WIDTH = 10,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH+1:0] count,
    output logic               ram_full
);

    localparam int SKID_DEPTH = skid_depth(LATENCY);
    localparam int SW         = clog2(SKID_DEPTH + 1);
    localparam logic [SW:0] SKID_LIM = SKID_DEPTH[SW:0];

    logic [A_WIDTH:0]   wr_ptr;
    logic [A_WIDTH:0]   rd_ptr;
    logic [A_WIDTH:0]   ram_cnt;
    logic [LATENCY-1:0] tag;
    logic [SW-1:0]      inflight;
    logic [SW-1:0]      skid_cnt;
    logic [SW:0]        committed;
    logic [D_WIDTH-1:0] ram_dout;
    logic               push;
    logic               pop;
    logic               issue;
    logic               ret;

    assign ram_cnt  = wr_ptr - rd_ptr;
    assign ram_full = (ram_cnt == {1'b1, {A_WIDTH{1'b0}}});
    assign in_ready = !rst && !ram_full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Issue only against registered state: words in skid plus words still in the RAM pipe.
    assign committed = {1'b0, skid_cnt} + {1'b0, inflight};
    assign issue     = (ram_cnt != '0) && (committed < SKID_LIM);
    assign ret       = tag[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag      <= '0;
            inflight <= '0;
            count    <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            tag[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            inflight <= inflight + SW'(issue) - SW'(ret);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sdp_ram #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .LATENCY (LATENCY)
    ) u_ram (
        .clk    (clk),
        .we     (push),
        .w_addr (wr_ptr[A_WIDTH-1:0]),
        .din    (in_data),
        .r_addr (rd_ptr[A_WIDTH-1:0]),
        .dout   (ram_dout)
    );

    sdp_ram_fifo_skid #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (SKID_DEPTH),
        .CW      (SW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (ret),
        .push_data (ram_dout),
        .pop       (pop),
        .head      (out_data),
        .cnt       (skid_cnt)
    );

    assign out_valid = (skid_cnt != '0);

endmodule

// File: tb/tb_sdp_ram_fifo.sv
module tb_sdp_ram_fifo;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int CAP = 2**AW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;
    logic          ram_full;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] q [$];

    sdp_ram_fifo #(
        .D_WIDTH (DW),
        .A_WIDTH (AW),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .ram_full  (ram_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered queue of accepted words, updated on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_count", int'(count), 0);
            check("rst_in_ready", int'(in_ready), 0);
        end else begin
            check("count_model", int'(count), q.size());
            check("count_max", int'(count <= 6'(CAP + LAT + 2)), 1);
            if (q.size() < CAP) check("in_ready_model", int'(in_ready), 1);
            if (out_valid) begin
                check("out_nonempty", int'(q.size() != 0), 1);
                if (q.size() != 0) check("out_data_model", int'(out_data), int'(q[0]));
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic a;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        #1;
        check("in_ready_release", int'(in_ready), 1);
        check("ram_full_release", int'(ram_full), 0);

        // Single word: push cycle 0, visible cycle 4.
        tick();
        in_valid = 1'b1;
        in_data = 16'h00A5;
        out_ready = 1'b1;
        check("t1_c0_out_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("t1_early_out_valid", int'(out_valid), 0);
            check("t1_count1", int'(count), 1);
            tick();
        end
        check("t1_c4_out_valid", int'(out_valid), 1);
        check("t1_c4_out_data", int'(out_data), 16'h00A5);
        check("t1_c4_count", int'(count), 1);
        tick();
        check("t1_c5_out_valid", int'(out_valid), 0);
        check("t1_c5_count", int'(count), 0);

        // Continuous streaming at one word per cycle.
        for (int i = 0; i < 5000; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            check("t2_in_ready", int'(in_ready), 1);
            if (i >= 4) check("t2_out_valid", int'(out_valid), 1);
            check("t2_count_le5", int'(count <= 6'd5), 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();
        check("t2_drained", int'(count), 0);

        // Fill with output stalled: RAM capacity plus skid depth.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_data = 16'd1000;
        for (int c = 0; c < 60; c++) begin
            a = in_ready;
            tick();
            if (a) begin
                acc++;
                in_data = DW'(1000 + acc);
            end
        end
        in_valid = 1'b0;
        check("t3_accepted", acc, 20);
        check("t3_count", int'(count), 20);
        check("t3_in_ready_full", int'(in_ready), 0);
        check("t3_ram_full", int'(ram_full), 1);
        out_ready = 1'b1;
        check("t3_d0_in_ready", int'(in_ready), 0);
        tick();
        check("t3_d1_in_ready", int'(in_ready), 0);
        tick();
        check("t3_d2_in_ready", int'(in_ready), 1);
        check("t3_d2_count", int'(count), 18);
        repeat (30) tick();
        check("t3_drained", int'(count), 0);

        // Random handshakes.
        n = 0;
        for (int c = 0; c < 20000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = DW'(2000 + n);
            a = in_valid && in_ready;
            tick();
            if (a) n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        check("t4_drained", int'(count), 0);

        // Reset while reads are in the RAM pipe.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = DW'(16'h0111 * (k + 1));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t5_out_valid", int'(out_valid), 0);
            check("t5_count", int'(count), 0);
            tick();
        end

        // Near-full operation across many pointer wraps.
        out_ready = 1'b0;
        in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 18; c++) begin
            in_data = DW'(5000 + n);
            a = in_ready;
            tick();
            if (a) n++;
        end
        check("t6_prefill", int'(count), 18);
        for (int c = 0; c < 600 && n < 118; c++) begin
            in_data = DW'(5000 + n);
            out_ready = 1'($urandom_range(0, 1));
            a = in_ready;
            tick();
            if (a) n++;
        end
        check("t6_pushed", n, 118);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        check("t6_drained", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
